// File: rtl/dds_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dds_phase_ctrl
// Phase accumulator with handshaked, phase-continuous FTW/offset updates and
// quarter-wave folding for an external synchronous sine ROM.
// Option : define DDS_PHASE_DITHER_EN for LFSR phase dither below truncation.
// Rev    : 1.0  initial release
// ============================================================================
module dds_phase_ctrl #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 8,
  parameter int LUT_AW  = 6,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_ftw,
  input  logic [PHASE_W-1:0] cfg_poff,
  input  logic               cfg_sync,
  output logic [LUT_AW-1:0]  lut_addr,
  input  logic [DATA_W-1:0]  lut_data,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_hold = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_act_q, ftw_sh_q;
  logic [PHASE_W-1:0] poff_act_q, poff_sh_q;
  logic               sync_sh_q;
  logic               en_d_q;
  logic [ACC_W:0]     acc_sum;
  logic               wrap, apply, take;
  logic [PHASE_W-1:0] phase_base, phase;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx;
  logic [LUT_AW-1:0]  lut_addr_q;
  logic               sign1_q, v1_q, sign2_q, v2_q;
  logic [DATA_W-1:0]  sample_q;
  logic               sample_valid_q;
  logic [DATA_W-2:0]  mag;
  logic               unused_lut_msb;

  assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign wrap    = en & acc_sum[ACC_W];
  assign take    = (state_q == c_st_idle) & cfg_valid;
  // Updates land only where the phase step is invisible: sync, stall, FTW=0 or wrap.
  assign apply   = (state_q == c_st_hold) &
                   (sync_sh_q | ~en | (ftw_act_q == '0) | wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= c_st_idle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (cfg_valid) state_d = c_st_hold;
      c_st_hold: if (apply)     state_d = c_st_idle;
      default:                  state_d = c_st_idle;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == c_st_idle);
  end

  always_comb begin
    acc_d = acc_q;
    if (en)                acc_d = acc_sum[ACC_W-1:0];
    if (apply & sync_sh_q) acc_d = '0;
  end

`ifdef DDS_PHASE_DITHER_EN
  localparam int c_frac_w = ACC_W - PHASE_W;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [c_frac_w:0] frac_sum;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  // Only the carry out of the fractional bits reaches the truncated phase.
  assign frac_sum   = {1'b0, acc_q[c_frac_w-1:0]} + {1'b0, lfsr_q[c_frac_w-1:0]};
  assign phase_base = acc_q[ACC_W-1 -: PHASE_W] + {{(PHASE_W-1){1'b0}}, frac_sum[c_frac_w]};
`else
  assign phase_base = acc_q[ACC_W-1 -: PHASE_W];
`endif

  assign phase = phase_base + poff_act_q;
  assign quad  = phase[PHASE_W-1 -: 2];
  assign idx   = phase[LUT_AW-1:0];

  assign mag            = lut_data[DATA_W-2:0];
  assign unused_lut_msb = lut_data[DATA_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      ftw_act_q      <= '0;
      poff_act_q     <= '0;
      ftw_sh_q       <= '0;
      poff_sh_q      <= '0;
      sync_sh_q      <= 1'b0;
      en_d_q         <= 1'b0;
      lut_addr_q     <= '0;
      sign1_q        <= 1'b0;
      v1_q           <= 1'b0;
      sign2_q        <= 1'b0;
      v2_q           <= 1'b0;
      sample_q       <= {1'b1, {(DATA_W-1){1'b0}}};
      sample_valid_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      en_d_q <= en;
      if (take) begin
        ftw_sh_q  <= cfg_ftw;
        poff_sh_q <= cfg_poff;
        sync_sh_q <= cfg_sync;
      end
      if (apply) begin
        ftw_act_q  <= ftw_sh_q;
        poff_act_q <= poff_sh_q;
      end
      lut_addr_q <= quad[0] ? ~idx : idx;
      sign1_q    <= quad[1];
      v1_q       <= en_d_q;
      sign2_q    <= sign1_q;
      v2_q       <= v1_q;
      // Negative half: M-1-mag is the bitwise complement of mag below the MSB.
      if (v2_q) sample_q <= sign2_q ? {1'b0, ~mag} : {1'b1, mag};
      sample_valid_q <= v2_q;
    end
  end

  assign lut_addr     = lut_addr_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dds_phase_ctrl
// Randomised self-checking bench for dds_phase_ctrl against a cycle history model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dds_phase_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_ftw;
  logic [7:0]  cfg_poff;
  logic        cfg_sync;
  logic [5:0]  lut_addr;
  logic [7:0]  lut_data;
  logic [7:0]  sample;
  logic        sample_valid;

  dds_phase_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ftw      (cfg_ftw),
    .cfg_poff     (cfg_poff),
    .cfg_sync     (cfg_sync),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // External synchronous quarter-wave ROM; MSB filled with junk on purpose.
  logic [7:0] rom [0:63];
  always @(posedge clk) lut_data <= rom[lut_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: architectural state plus per-edge history.
  int unsigned m_acc, m_ftw, m_poff, m_shf, m_shp;
  bit          m_sync, m_hold, m_took;
  int unsigned m_sample;
  int unsigned hist_acc  [0:8191];
  int unsigned hist_poff [0:8191];
  bit          hist_en   [0:8191];
  int          n = 3;

  function automatic int unsigned phase_of(input int unsigned a, input int unsigned po);
    return ((a >> 16) + po) % 256;
  endfunction

  function automatic int unsigned addr_of(input int unsigned p);
    if (p < 64)       return p;
    else if (p < 128) return 127 - p;
    else if (p < 192) return p - 128;
    else              return 255 - p;
  endfunction

  function automatic int unsigned samp_of(input int unsigned p);
    int unsigned mag;
    mag = rom[addr_of(p)] % 128;
    return (p < 128) ? 128 + mag : 127 - mag;
  endfunction

  always @(posedge clk) begin
    int unsigned sum;
    bit apply, exp_v;
    int unsigned exp_addr;
    n++;
    m_took = 0;
    if (!rst_n) begin
      m_acc = 0; m_ftw = 0; m_poff = 0; m_hold = 0; m_sample = 128;
      for (int k = 0; k < 4; k++) begin
        hist_acc[n-k] = 0; hist_poff[n-k] = 0; hist_en[n-k] = 0;
      end
    end else begin
      sum   = m_acc + m_ftw;
      apply = m_hold && (m_sync || !en || m_ftw == 0 || sum >= 32'h0100_0000);
      if (en) m_acc = sum % 32'h0100_0000;
      if (apply && m_sync) m_acc = 0;
      if (apply) begin
        m_ftw = m_shf; m_poff = m_shp; m_hold = 0;
      end else if (!m_hold && cfg_valid) begin
        m_shf = cfg_ftw; m_shp = cfg_poff; m_sync = cfg_sync; m_hold = 1; m_took = 1;
      end
      hist_acc[n] = m_acc; hist_poff[n] = m_poff; hist_en[n] = en;
    end
    exp_addr = addr_of(phase_of(hist_acc[n-1], hist_poff[n-1]));
    exp_v    = hist_en[n-3];
    if (exp_v) m_sample = samp_of(phase_of(hist_acc[n-3], hist_poff[n-3]));
    #1;
    chk("cfg_ready", cfg_ready, !m_hold);
    chk("acc", dut.acc_q, m_acc);
    chk("lut_addr", lut_addr, exp_addr);
    chk("sample_valid", sample_valid, exp_v);
    chk("sample", sample, m_sample);
  end

  task automatic cfg_write(input logic [23:0] f, input logic [7:0] p, input logic s);
    cfg_ftw = f; cfg_poff = p; cfg_sync = s; cfg_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_took) begin
        cfg_valid = 1'b0;
        return;
      end
    end
    cfg_valid = 1'b0;
    chk("cfg_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, cfg_ready, 1);
    chk({tag, "_sample"}, sample, 8'd128);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_addr"}, lut_addr, 0);
  endtask

  initial begin
    bit found;
    clk = 0; rst_n = 1; en = 0; cfg_valid = 0;
    cfg_ftw = 0; cfg_poff = 0; cfg_sync = 0;
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    #1 rst_n = 0;
    #2 check_reset_outputs("rst0");
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Full sine sweep from a synced start
    cfg_write(24'h010000, 8'h00, 1'b1);
    en = 1;
    repeat (520) @(negedge clk);

    // Phase-continuous FTW change at acc=0x400000, applied on the wrap
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (m_acc == 32'h0040_0000) found = 1;
      else @(negedge clk);
    end
    chk("acc_reach", found, 1);
    cfg_write(24'h020000, 8'h00, 1'b0);
    repeat (300) @(negedge clk);

    // Sync update with stalls
    en = 0;
    cfg_write(24'h030000, 8'h10, 1'b1);
    for (int k = 0; k < 200; k++) begin
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    // Frozen phase with offsets
    en = 1;
    cfg_write(24'h000000, 8'h40, 1'b1);
    repeat (20) @(negedge clk);
    cfg_write(24'h000000, 8'hC0, 1'b0);
    repeat (20) @(negedge clk);

    // Reset while a config is pending
    cfg_write(24'h000100, 8'h00, 1'b1);
    repeat (5) @(negedge clk);
    cfg_write(24'h123456, 8'h55, 1'b0);
    chk("hold_pending", cfg_ready, 0);
    rst_n = 0;
    #1 check_reset_outputs("rst_hold");
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      if (m_took) cfg_valid = 0;
      en = ($urandom % 4) != 0;
      if (!cfg_valid && ($urandom % 16) == 0) begin
        cfg_valid = 1;
        case ($urandom % 4)
          0:       cfg_ftw = 24'h000000;
          1:       cfg_ftw = 24'($urandom % 32'h0002_0000);
          2:       cfg_ftw = 24'($urandom);
          default: cfg_ftw = 24'h010000;
        endcase
        cfg_poff = 8'($urandom);
        cfg_sync = ($urandom % 4) == 0;
      end
      @(negedge clk);
    end
    cfg_valid = 0;
    en = 0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
